// File: rtl/serdes_8b10b_link_init.sv
`default_nettype none
// ============================================================================
// Module      : serdes_8b10b_link_init
// Description : Link bring-up and supervision controller for the 8b10b SERDES.
//               Sequences datapath reset, TX comma training and RX comma
//               alignment, declares link-up, then watches the RX code-error
//               rate and forces a retrain when it gets too high.
// Ports       : clk_byte     - byte clock
//               rst_n        - asynchronous active-low reset
//               rx_valid     - decoder symbol valid
//               rx_comma     - K28.5 at current boundary (qualified by rx_valid)
//               rx_code_err  - code/disparity error (qualified by rx_valid)
//               pcs_rst_n    - active-low encoder/decoder datapath reset
//               tx_idle_en   - transmit idle/comma ordered sets
//               rx_align_en  - enable word-aligner boundary search
//               link_up      - link trained and healthy
//               retrain_cnt  - ERR_RECOVER entries, saturating at 255
//               state        - encoded FSM state for debug
// Revision    : 1.0 - initial release
// ============================================================================
module serdes_8b10b_link_init #(
  parameter int PCS_RST_CYCLES   = 16,
  parameter int TRAIN_CYCLES     = 1024,
  parameter int COMMA_LOCK_COUNT = 8,
  parameter int ALIGN_TIMEOUT    = 4096,
  parameter int ERR_WINDOW       = 256,
  parameter int ERR_THRESH       = 4
) (
  input  logic       clk_byte,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic       rx_comma,
  input  logic       rx_code_err,
  output logic       pcs_rst_n,
  output logic       tx_idle_en,
  output logic       rx_align_en,
  output logic       link_up,
  output logic [7:0] retrain_cnt,
  output logic [2:0] state
);

  // The phase counter is shared by RESET, TX_TRAIN, RX_ALIGN and ERR_RECOVER,
  // so it is sized for the longest of those dwell times.
  localparam int PH_MAX_A = (PCS_RST_CYCLES > TRAIN_CYCLES) ? PCS_RST_CYCLES : TRAIN_CYCLES;
  localparam int PH_MAX   = (PH_MAX_A > ALIGN_TIMEOUT) ? PH_MAX_A : ALIGN_TIMEOUT;
  localparam int PH_W     = $clog2(PH_MAX + 1);
  localparam int CM_W     = $clog2(COMMA_LOCK_COUNT + 1);
  localparam int WN_W     = $clog2(ERR_WINDOW + 1);
  localparam int ER_W     = $clog2(ERR_THRESH + 1);

  localparam logic [PH_W-1:0] c_pcs_last   = PH_W'(PCS_RST_CYCLES - 1);
  localparam logic [PH_W-1:0] c_train_last = PH_W'(TRAIN_CYCLES - 1);
  localparam logic [PH_W-1:0] c_align_last = PH_W'(ALIGN_TIMEOUT - 1);
  localparam logic [CM_W-1:0] c_lock_last  = CM_W'(COMMA_LOCK_COUNT - 1);
  localparam logic [WN_W-1:0] c_win_last   = WN_W'(ERR_WINDOW - 1);
  localparam logic [ER_W-1:0] c_thresh     = ER_W'(ERR_THRESH);

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_TX_TRAIN    = 3'd1,
    ST_RX_ALIGN    = 3'd2,
    ST_LINK_UP     = 3'd3,
    ST_ERR_RECOVER = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [CM_W-1:0] comma_q, comma_d;
  logic [WN_W-1:0] win_q, win_d;
  logic [ER_W-1:0] err_q, err_d;
  logic [7:0]      retrain_q, retrain_d;
  logic            pcs_rst_n_q, pcs_rst_n_d;
  logic            tx_idle_en_q, tx_idle_en_d;
  logic            rx_align_en_q, rx_align_en_d;
  logic            link_up_q, link_up_d;

  logic            comma_ok;
  logic            win_wrap;
  logic [ER_W-1:0] err_new;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    comma_d   = comma_q;
    win_d     = win_q;
    err_d     = err_q;
    retrain_d = retrain_q;
    comma_ok  = rx_valid & rx_comma & ~rx_code_err;
    win_wrap  = 1'b0;
    err_new   = err_q;

    case (state_q)
      ST_RESET, ST_ERR_RECOVER: begin
        if (phase_q == c_pcs_last) state_d = ST_TX_TRAIN;
        else                       phase_d = phase_q + PH_W'(1);
      end
      ST_TX_TRAIN: begin
        if (phase_q == c_train_last) state_d = ST_RX_ALIGN;
        else                         phase_d = phase_q + PH_W'(1);
      end
      ST_RX_ALIGN: begin
        // An error clears the run even if a comma is flagged alongside it.
        if (rx_valid & rx_code_err) comma_d = '0;
        else if (comma_ok)          comma_d = comma_q + CM_W'(1);
        // Lock is taken on the edge that completes the run and beats timeout.
        if (comma_ok && (comma_q == c_lock_last)) state_d = ST_LINK_UP;
        else if (phase_q == c_align_last)         state_d = ST_ERR_RECOVER;
        else                                      phase_d = phase_q + PH_W'(1);
      end
      ST_LINK_UP: begin
        if (rx_valid) begin
          win_wrap = (win_q == c_win_last);
          win_d    = win_wrap ? '0 : win_q + WN_W'(1);
          // The wrap cycle opens a new window, so its own error seeds it.
          err_new  = win_wrap ? ER_W'(rx_code_err) : err_q + ER_W'(rx_code_err);
          err_d    = err_new;
          if (err_new == c_thresh) state_d = ST_ERR_RECOVER;
        end
      end
      default: state_d = ST_RESET;
    endcase

    if (state_d != state_q) begin
      phase_d = '0;
      comma_d = '0;
      win_d   = '0;
      err_d   = '0;
      if ((state_d == ST_ERR_RECOVER) && (retrain_q != 8'hFF))
        retrain_d = retrain_q + 8'd1;
    end

    // Outputs are decoded from the next state so they register alongside it.
    pcs_rst_n_d   = (state_d == ST_TX_TRAIN) || (state_d == ST_RX_ALIGN) ||
                    (state_d == ST_LINK_UP);
    tx_idle_en_d  = (state_d == ST_TX_TRAIN) || (state_d == ST_RX_ALIGN);
    rx_align_en_d = (state_d == ST_RX_ALIGN);
    link_up_d     = (state_d == ST_LINK_UP);
  end

  always_ff @(posedge clk_byte or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RESET;
      phase_q       <= '0;
      comma_q       <= '0;
      win_q         <= '0;
      err_q         <= '0;
      retrain_q     <= '0;
      pcs_rst_n_q   <= 1'b0;
      tx_idle_en_q  <= 1'b0;
      rx_align_en_q <= 1'b0;
      link_up_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      comma_q       <= comma_d;
      win_q         <= win_d;
      err_q         <= err_d;
      retrain_q     <= retrain_d;
      pcs_rst_n_q   <= pcs_rst_n_d;
      tx_idle_en_q  <= tx_idle_en_d;
      rx_align_en_q <= rx_align_en_d;
      link_up_q     <= link_up_d;
    end
  end

  assign pcs_rst_n   = pcs_rst_n_q;
  assign tx_idle_en  = tx_idle_en_q;
  assign rx_align_en = rx_align_en_q;
  assign link_up     = link_up_q;
  assign retrain_cnt = retrain_q;
  assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_serdes_8b10b_link_init.sv
`default_nettype none
// ============================================================================
// Module      : tb_serdes_8b10b_link_init
// Description : Self-checking bench for serdes_8b10b_link_init. A behavioural
//               model tracks the link phase and the time/event counts of the
//               link rules; its outputs are compared to the DUT every cycle.
//               Directed scenarios pin the model with literal expectations,
//               then randomized traffic exercises lock, recovery and resets.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serdes_8b10b_link_init;

  localparam int P  = 4;
  localparam int T  = 16;
  localparam int C  = 8;
  localparam int A  = 64;
  localparam int W  = 32;
  localparam int TH = 4;

  logic       clk_byte    = 1'b0;
  logic       rst_n       = 1'b0;
  logic       rx_valid    = 1'b0;
  logic       rx_comma    = 1'b0;
  logic       rx_code_err = 1'b0;
  logic       pcs_rst_n;
  logic       tx_idle_en;
  logic       rx_align_en;
  logic       link_up;
  logic [7:0] retrain_cnt;
  logic [2:0] state;

  int vectors     = 0;
  int miscompares = 0;

  // Model: phase 0=reset, 1=train, 2=align, 3=up, 4=recover
  int m_state   = 0;
  int m_age     = 0;  // edges spent in the current phase
  int m_run     = 0;  // clean commas since the last error in align
  int m_nvalid  = 0;  // valid symbols since link came up
  int m_errs    = 0;  // errors in the current window
  int m_retrain = 0;

  serdes_8b10b_link_init #(
    .PCS_RST_CYCLES  (P),
    .TRAIN_CYCLES    (T),
    .COMMA_LOCK_COUNT(C),
    .ALIGN_TIMEOUT   (A),
    .ERR_WINDOW      (W),
    .ERR_THRESH      (TH)
  ) dut (
    .clk_byte   (clk_byte),
    .rst_n      (rst_n),
    .rx_valid   (rx_valid),
    .rx_comma   (rx_comma),
    .rx_code_err(rx_code_err),
    .pcs_rst_n  (pcs_rst_n),
    .tx_idle_en (tx_idle_en),
    .rx_align_en(rx_align_en),
    .link_up    (link_up),
    .retrain_cnt(retrain_cnt),
    .state      (state)
  );

  always #5 clk_byte = ~clk_byte;

  task automatic model_reset();
    m_state = 0; m_age = 0; m_run = 0; m_nvalid = 0; m_errs = 0; m_retrain = 0;
  endtask

  task automatic model_step(input logic v, input logic c, input logic e);
    int nxt;
    nxt = m_state;
    case (m_state)
      0, 4: if (m_age + 1 == P) nxt = 1;
      1:    if (m_age + 1 == T) nxt = 2;
      2: begin
        if (v && e)      m_run = 0;
        else if (v && c) m_run = m_run + 1;
        if (m_run == C)           nxt = 3;
        else if (m_age + 1 == A)  nxt = 4;
      end
      3: begin
        if (v) begin
          m_nvalid = m_nvalid + 1;
          if (m_nvalid % W == 0) m_errs = e ? 1 : 0;
          else                   m_errs = m_errs + (e ? 1 : 0);
          if (m_errs == TH) nxt = 4;
        end
      end
      default: nxt = 0;
    endcase
    if (nxt != m_state) begin
      m_age = 0; m_run = 0; m_nvalid = 0; m_errs = 0;
      if (nxt == 4 && m_retrain < 255) m_retrain = m_retrain + 1;
      m_state = nxt;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  initial forever begin
    @(posedge clk_byte or negedge rst_n);
    if (!rst_n) model_reset();
    else        model_step(rx_valid, rx_comma, rx_code_err);
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    logic       e_pcs, e_idle, e_align, e_up;
    logic [7:0] e_rt;
    logic [2:0] e_st;
    @(negedge clk_byte);
    e_pcs   = (m_state == 1) || (m_state == 2) || (m_state == 3);
    e_idle  = (m_state == 1) || (m_state == 2);
    e_align = (m_state == 2);
    e_up    = (m_state == 3);
    e_rt    = 8'(m_retrain);
    e_st    = 3'(m_state);
    vectors = vectors + 1;
    if ({pcs_rst_n, tx_idle_en, rx_align_en, link_up, retrain_cnt, state} !==
        {e_pcs, e_idle, e_align, e_up, e_rt, e_st}) begin
      miscompares = miscompares + 1;
      $display("FAIL model_cmp t=%0t got pcs=%b idle=%b align=%b up=%b rt=%0d st=%0d, expected pcs=%b idle=%b align=%b up=%b rt=%0d st=%0d",
               $time, pcs_rst_n, tx_idle_en, rx_align_en, link_up, retrain_cnt, state,
               e_pcs, e_idle, e_align, e_up, e_rt, e_st);
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic c, input logic e);
    rx_valid = v; rx_comma = c; rx_code_err = e;
  endtask

  // Advance n active edges; returns 2 time units after the last edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_byte);
      #2;
    end
  endtask

  // Reset, then release so the next posedge is edge 1.
  task automatic restart();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk_byte);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic bring_up();
    restart();
    tick(P + T);
    drive(1'b1, 1'b1, 1'b0);
    tick(C);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int low_seen;
    logic v, c, e;
    int pct;

    // Reset state before any release
    #7;
    chk("reset_state", 8'(state), 8'd0);
    chk("reset_pcs_rst_n", 8'(pcs_rst_n), 8'd0);

    // Clean bring-up
    restart();
    drive(1'b1, 1'b1, 1'b0);
    tick(3);
    chk("bringup_pcs_low_e3", 8'(pcs_rst_n), 8'd0);
    tick(1);
    chk("bringup_pcs_high_e4", 8'(pcs_rst_n), 8'd1);
    chk("bringup_state_e4", 8'(state), 8'd1);
    tick(15);
    chk("bringup_state_e19", 8'(state), 8'd1);
    tick(1);
    chk("bringup_state_e20", 8'(state), 8'd2);
    chk("bringup_align_e20", 8'(rx_align_en), 8'd1);
    tick(7);
    chk("bringup_link_e27", 8'(link_up), 8'd0);
    tick(1);
    chk("bringup_link_e28", 8'(link_up), 8'd1);
    chk("bringup_retrain", retrain_cnt, 8'd0);

    // Broken commas: 5 commas, 1 error, 8 commas
    restart();
    tick(P + T);
    chk("broken_state_align", 8'(state), 8'd2);
    drive(1'b1, 1'b1, 1'b0);
    tick(5);
    drive(1'b1, 1'b0, 1'b1);
    tick(1);
    drive(1'b1, 1'b1, 1'b0);
    tick(7);
    chk("broken_link_at13", 8'(link_up), 8'd0);
    tick(1);
    chk("broken_link_at14", 8'(link_up), 8'd1);

    // Align timeout with no commas
    restart();
    tick(P + T);
    for (int i = 0; i < A - 1; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      tick(1);
    end
    chk("timeout_state_before", 8'(state), 8'd2);
    tick(1);
    chk("timeout_state_recover", 8'(state), 8'd4);
    chk("timeout_retrain", retrain_cnt, 8'd1);
    chk("timeout_pcs_low", 8'(pcs_rst_n), 8'd0);
    tick(P - 1);
    chk("timeout_pcs_still_low", 8'(pcs_rst_n), 8'd0);
    tick(1);
    chk("timeout_state_train", 8'(state), 8'd1);
    chk("timeout_pcs_high", 8'(pcs_rst_n), 8'd1);

    // Error threshold in LINK_UP
    bring_up();
    chk("thresh_link_up", 8'(link_up), 8'd1);
    for (int i = 1; i < 20; i++) begin
      drive(1'b1, 1'b0, (i == 3) || (i == 7) || (i == 12));
      tick(1);
    end
    chk("thresh_link_before", 8'(link_up), 8'd1);
    drive(1'b1, 1'b0, 1'b1);
    tick(1);
    chk("thresh_link_dropped", 8'(link_up), 8'd0);
    chk("thresh_retrain", retrain_cnt, 8'd1);

    // Window wrap: 3 errors in window 1, 3 in window 2 (one on the wrap cycle)
    bring_up();
    low_seen = 0;
    for (int n = 1; n < 60; n++) begin
      drive(1'b1, 1'($urandom_range(0, 1)),
            (n == 5) || (n == 10) || (n == 20) || (n == 32) || (n == 40) || (n == 50));
      tick(1);
      if (link_up !== 1'b1) low_seen = 1;
    end
    chk("wrap_link_held", 8'(low_seen), 8'd0);
    drive(1'b1, 1'b0, 1'b1);
    tick(1);
    chk("wrap_fourth_in_window2", 8'(link_up), 8'd0);

    // Async reset mid LINK_UP with retrain_cnt=2
    restart();
    drive(1'b0, 1'b0, 1'b0);
    tick(P + T + A + P + T + A + P + T);
    drive(1'b1, 1'b1, 1'b0);
    tick(C);
    chk("async_pre_state", 8'(state), 8'd3);
    chk("async_pre_retrain", retrain_cnt, 8'd2);
    #1 rst_n = 1'b0;
    #1;
    chk("async_pcs", 8'(pcs_rst_n), 8'd0);
    chk("async_idle", 8'(tx_idle_en), 8'd0);
    chk("async_align", 8'(rx_align_en), 8'd0);
    chk("async_link", 8'(link_up), 8'd0);
    chk("async_retrain", retrain_cnt, 8'd0);
    chk("async_state", 8'(state), 8'd0);
    @(posedge clk_byte);
    #2 rst_n = 1'b1;
    tick(P + T + C);
    chk("async_rebringup_link", 8'(link_up), 8'd1);

    // Randomized traffic at increasing error rates
    for (int it = 0; it < 8; it++) begin
      restart();
      pct = it * 2;
      for (int k = 0; k < 400; k++) begin
        v = ($urandom_range(0, 99) < 85);
        c = ($urandom_range(0, 99) < 75);
        e = ($urandom_range(0, 99) < pct);
        drive(v, c, e);
        tick(1);
        if ($urandom_range(0, 999) == 0) begin
          #1 rst_n = 1'b0;
          #1 rst_n = 1'b1;
        end
      end
    end

    drive(1'b0, 1'b0, 1'b0);
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
